// File: rtl/fp12_pkg.sv
// Shared FP12 definitions: field widths, exponent bias, special encodings and
// the sequencer state type used by the subtractor.
package fp12_pkg;

   localparam int EXP_W  = 4;
   localparam int FRAC_W = 7;
   localparam int MANT_W = FRAC_W + 1;
   localparam int BIAS   = 7;

   localparam logic [EXP_W-1:0]        EXP_MAX   = EXP_W'(2 * BIAS + 1);
   localparam logic [11:0]             ZERO      = 12'h000;
   localparam logic [EXP_W+FRAC_W-1:0] SAT_MAG   = 11'h7FF;
   localparam logic [3:0]              MAX_SHIFT = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ALIGN,
      S_ADDSUB,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   // Both signed zeros carry an all-zero magnitude field.
   function automatic logic is_zero(input logic [11:0] v);
      return v[EXP_W+FRAC_W-1:0] == '0;
   endfunction

endpackage

// File: rtl/fp12_cla9.sv
// 9-bit carry-lookahead adder/subtractor; subtraction inverts y and relies on
// the caller to supply the +1 through cin.
module fp12_cla9 (
   input  logic [8:0] x,
   input  logic [8:0] y,
   input  logic       sub,
   input  logic       cin,
   output logic [8:0] sum
);

   logic [8:0] yy;
   logic [8:0] g;
   logic [8:0] p;
   logic [8:0] c;
   logic [9:0] gc;
   logic       term;

   // Each carry is the flattened sum-of-products over all generate terms below it.
   always_comb begin
      yy   = y ^ {9{sub}};
      g    = x & yy;
      p    = x ^ yy;
      gc   = {g, cin};
      c    = '0;
      term = 1'b0;
      c[0] = cin;
      for (int i = 1; i < 9; i++) begin
         for (int j = 0; j <= i; j++) begin
            term = gc[j];
            for (int k = j; k < i; k++) begin
               term = term & p[k];
            end
            c[i] = c[i] | term;
         end
      end
      sum = p ^ c;
   end

endmodule

// File: rtl/fp12_sub_seq.sv
// Multi-cycle FP12 subtractor z = a - b with valid/ready handshakes.
// Define FP12_SUB_ROUND_EN for guard/sticky tracking and round-to-nearest-even.
module fp12_sub_seq
   import fp12_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] a,
   input  logic [11:0] b,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [11:0] z,
   output logic        ovf,
   output logic        unf,
   output logic        out_valid,
   input  logic        out_ready
);

   state_t             state;
   logic [11:0]        a_r, b_r;
   logic [MANT_W-1:0]  xm, ym;
   logic [EXP_W-1:0]   xe, ex;
   logic [3:0]         cnt;
   logic               sign, sub_op;
   logic [8:0]         r;
   logic [8:0]         sum;
   logic               cla_cin;
   logic               zero_res;

   logic               a_big;
   logic [MANT_W-1:0]  ma, mb;
   logic [EXP_W-1:0]   xe_n, ediff, shift_n;

   logic [8:0]         norm_r;
   logic [EXP_W-1:0]   norm_e;
   logic               norm_done;
   logic               shift_in;

`ifdef FP12_SUB_ROUND_EN
   logic               g, s;
   logic [1:0]         low;
   logic               norm_g, norm_s;
   logic               rnd;
   logic [8:0]         m9;
`endif

   // Operand ordering: the larger magnitude becomes X, ties keep a as X.
   always_comb begin
      a_big   = a_r[10:0] >= b_r[10:0];
      ma      = is_zero(a_r) ? '0 : {1'b1, a_r[FRAC_W-1:0]};
      mb      = is_zero(b_r) ? '0 : {1'b1, b_r[FRAC_W-1:0]};
      xe_n    = a_big ? a_r[10:7] : b_r[10:7];
      ediff   = a_big ? (a_r[10:7] - b_r[10:7]) : (b_r[10:7] - a_r[10:7]);
      shift_n = (ediff > MAX_SHIFT) ? MAX_SHIFT : ediff;
   end

`ifdef FP12_SUB_ROUND_EN
   // Bits below the mantissa borrow from it when subtracting a nonzero tail.
   assign low      = sub_op ? (2'b00 - {g, s}) : {g, s};
   assign cla_cin  = sub_op & ~(g | s);
   assign zero_res = (sum == '0) && (low == '0);
   assign shift_in = g;
`else
   assign cla_cin  = sub_op;
   assign zero_res = (sum == '0);
   assign shift_in = 1'b0;
`endif

   fp12_cla9 u_cla (
      .x   ({1'b0, xm}),
      .y   ({1'b0, ym}),
      .sub (sub_op),
      .cin (cla_cin),
      .sum (sum)
   );

   // One normalization step; norm_done means bit 7 is set after this step.
   always_comb begin
      norm_r    = r;
      norm_e    = ex;
      norm_done = 1'b1;
`ifdef FP12_SUB_ROUND_EN
      norm_g    = g;
      norm_s    = s;
`endif
      if (r[8]) begin
         norm_r = {1'b0, r[8:1]};
         norm_e = ex + 4'd1;
`ifdef FP12_SUB_ROUND_EN
         norm_g = r[0];
         norm_s = g | s;
`endif
      end else if (!r[7]) begin
         norm_r    = {r[7:0], shift_in};
         norm_e    = ex - 4'd1;
         norm_done = r[6];
`ifdef FP12_SUB_ROUND_EN
         norm_g    = s;
         norm_s    = 1'b0;
`endif
      end
   end

`ifdef FP12_SUB_ROUND_EN
   assign rnd = g & (s | r[0]);
   assign m9  = {1'b0, r[7:0]} + {8'b0, rnd};
`endif

   // Sequencer and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         z         <= ZERO;
         ovf       <= 1'b0;
         unf       <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         xm        <= '0;
         ym        <= '0;
         xe        <= '0;
         ex        <= '0;
         cnt       <= '0;
         sign      <= 1'b0;
         sub_op    <= 1'b0;
         r         <= '0;
`ifdef FP12_SUB_ROUND_EN
         g         <= 1'b0;
         s         <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  in_ready <= 1'b0;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               xm     <= a_big ? ma : mb;
               ym     <= a_big ? mb : ma;
               xe     <= xe_n;
               cnt    <= shift_n;
               sub_op <= (a_r[11] == b_r[11]);
               sign   <= a_big ? a_r[11] : ~b_r[11];
`ifdef FP12_SUB_ROUND_EN
               g      <= 1'b0;
               s      <= 1'b0;
`endif
               state  <= (shift_n == '0) ? S_ADDSUB : S_ALIGN;
            end
            S_ALIGN: begin
               ym  <= ym >> 1;
`ifdef FP12_SUB_ROUND_EN
               g   <= ym[0];
               s   <= s | g;
`endif
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_ADDSUB;
            end
            S_ADDSUB: begin
               r  <= sum;
               ex <= xe;
`ifdef FP12_SUB_ROUND_EN
               g  <= low[1];
               s  <= low[0];
`endif
               if (zero_res) begin
                  z         <= ZERO;
                  ovf       <= 1'b0;
                  unf       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  state <= S_NORM;
               end
            end
            S_NORM: begin
               if (r[8] && ex == EXP_MAX) begin
                  z         <= {sign, SAT_MAG};
                  ovf       <= 1'b1;
                  unf       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else if (!r[8] && !r[7] && ex == '0) begin
                  z         <= ZERO;
                  ovf       <= 1'b0;
                  unf       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  r  <= norm_r;
                  ex <= norm_e;
`ifdef FP12_SUB_ROUND_EN
                  g  <= norm_g;
                  s  <= norm_s;
                  if (norm_done) state <= S_ROUND;
`else
                  if (norm_done) begin
                     z         <= {sign, norm_e, norm_r[FRAC_W-1:0]};
                     ovf       <= 1'b0;
                     unf       <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end
`endif
               end
            end
`ifdef FP12_SUB_ROUND_EN
            S_ROUND: begin
               if (m9[8] && ex == EXP_MAX) begin
                  z   <= {sign, SAT_MAG};
                  ovf <= 1'b1;
               end else if (m9[8]) begin
                  z   <= {sign, ex + 4'd1, 7'b0};
                  ovf <= 1'b0;
               end else begin
                  z   <= {sign, ex, m9[FRAC_W-1:0]};
                  ovf <= 1'b0;
               end
               unf       <= 1'b0;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
`endif
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp12_sub_seq.sv
// Directed bench for fp12_sub_seq (truncating build) with hand-computed results.
module tb_fp12_sub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] a, b, z;
   logic        in_valid, in_ready, out_valid, out_ready, ovf, unf;
   int          checks = 0;
   int          errors = 0;
   int          lat;
   int          seen;

   always #5 clk = ~clk;

   fp12_sub_seq dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .z         (z),
      .ovf       (ovf),
      .unf       (unf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits for in_ready, then presents one operand pair for a single edge.
   task automatic applyStimulus(input logic [11:0] av, input logic [11:0] bv);
      int n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $error("[TB] FAIL in_ready_timeout observed=0 expected=1");
      end
      a = av;
      b = bv;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic waitResult(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!out_valid && cycles < 30);
      if (!out_valid) begin
         checks++;
         errors++;
         $error("[TB] FAIL out_valid_timeout observed=0 expected=1");
      end
   endtask

   task automatic runOp(input string tag, input logic [11:0] av, input logic [11:0] bv,
                        input logic [11:0] ez, input logic eo, input logic eu);
      int l;
      applyStimulus(av, bv);
      waitResult(l);
      checkOutput({tag, "_z"}, 32'(z), 32'(ez));
      checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eo));
      checkOutput({tag, "_unf"}, 32'(unf), 32'(eu));
      checkOutput({tag, "_lat_le_20"}, 32'(l <= 20), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_z", 32'(z), 32'h000);
      checkOutput("rst_ovf", 32'(ovf), 32'd0);
      checkOutput("rst_unf", 32'(unf), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      runOp("3m1",      12'h440, 12'h380, 12'h400, 1'b0, 1'b0);
      runOp("1m3",      12'h380, 12'h440, 12'hC00, 1'b0, 1'b0);
      runOp("1mneg1",   12'h380, 12'hB80, 12'h400, 1'b0, 1'b0);
      runOp("1m1",      12'h380, 12'h380, 12'h000, 1'b0, 1'b0);
      runOp("0m1",      12'h000, 12'h380, 12'hB80, 1'b0, 1'b0);
      runOp("ovf_pos",  12'h7FF, 12'hFFF, 12'h7FF, 1'b1, 1'b0);
      runOp("ovf_neg",  12'hFFF, 12'h7FF, 12'hFFF, 1'b1, 1'b0);
      runOp("unf",      12'h002, 12'h001, 12'h000, 1'b0, 1'b1);
      runOp("lshift2",  12'h3C0, 12'h3A0, 12'h280, 1'b0, 1'b0);
      runOp("1mneg3",   12'h380, 12'hC40, 12'h480, 1'b0, 1'b0);
      runOp("cap9",     12'h780, 12'h001, 12'h780, 1'b0, 1'b0);
      runOp("negz_z",   12'h800, 12'h000, 12'h000, 1'b0, 1'b0);
      runOp("trunc",    12'h400, 12'h301, 12'h3C0, 1'b0, 1'b0);

      // Back-pressure: result must hold while out_ready is low.
      out_ready = 1'b0;
      applyStimulus(12'h440, 12'h380);
      waitResult(lat);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_z", 32'(z), 32'h400);
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("release_valid", 32'(out_valid), 32'd0);
      checkOutput("release_in_ready", 32'(in_ready), 32'd1);

      // Reset in the middle of a long alignment.
      applyStimulus(12'h780, 12'h001);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst_z", 32'(z), 32'h000);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("midrst_no_output", 32'(seen), 32'd0);
      @(posedge clk);
      #1;
      runOp("after_rst", 12'h440, 12'h380, 12'h400, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
